write_back_unit: RTL and testbench

- Registered, handshaked write-back stage for the cache CPU pipeline. It is the successor to the stub write-back stage.
- Accepts one instruction per cycle from the MEM/WB register and selects the result source: ALU, link PC+4, or extracted/extended load data.
- Stalls when load data from the D-cache arrives after the instruction does.
- Drives the register-file write port, a one-cycle retire strobe, and a retired-instruction counter.

---
 rtl/wb_pkg.sv | 32 +++
 rtl/load_extract.sv | 56 +++++
 rtl/write_back_unit.sv | 178 +++++++++++++++++
 tb/tb_write_back_unit.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared definitions for the write-back stage: opcode_info layout, load funct3 codes, FSM states.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package wb_pkg;

    // opcode_info field positions; bits [11:6] are reserved and must be zero
    localparam int OPC_RD_WEN  = 0;
    localparam int OPC_IS_LOAD = 1;
    localparam int OPC_IS_LINK = 2;
    localparam int OPC_F3_LSB  = 3;
    localparam int OPC_F3_W    = 3;

    // load funct3 encodings
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;

    typedef enum logic {
        S_RUN      = 1'b0,
        S_WAIT_MEM = 1'b1
    } wb_state_e;

    // width of the in-word byte offset for a given datapath width
    function automatic int addr_lo_width(input int xlen);
        return $clog2(xlen / 8);
    endfunction

endpackage

// File: rtl/load_extract.sv
// Selects the addressed byte/half/word/dword from an aligned read word and sign/zero-extends it.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the result is used.
module load_extract
    import wb_pkg::*;
#(
    parameter int XLEN = 64,
    parameter int AW   = addr_lo_width(XLEN)
) (
    input  logic [XLEN-1:0] memdata,
    input  logic [AW-1:0]   addr_lo,
    input  logic [2:0]      funct3,
    output logic [XLEN-1:0] load_data
);

    // Misaligned halves/words fall back to the containing lane, so the low
    // offset bits are simply masked off before the shift.
    localparam logic [AW-1:0] HALF_MASK = ~AW'(1);
    localparam logic [AW-1:0] WORD_MASK = ~AW'(3);

    logic [AW+2:0]   byte_sh;
    logic [AW+2:0]   half_sh;
    logic [AW+2:0]   word_sh;
    logic [XLEN-1:0] byte_w;
    logic [XLEN-1:0] half_w;
    logic [XLEN-1:0] word_w;
    logic [7:0]      b_v;
    logic [15:0]     h_v;
    logic [31:0]     w_v;

    // lane selection and extension
    always_comb begin
        byte_sh = {addr_lo, 3'b000};
        half_sh = {addr_lo & HALF_MASK, 3'b000};
        word_sh = {addr_lo & WORD_MASK, 3'b000};
        byte_w  = memdata >> byte_sh;
        half_w  = memdata >> half_sh;
        word_w  = memdata >> word_sh;
        b_v     = byte_w[7:0];
        h_v     = half_w[15:0];
        w_v     = word_w[31:0];
        load_data = '0;
        case (funct3)
            F3_LB:   load_data = XLEN'($signed(b_v));
            F3_LH:   load_data = XLEN'($signed(h_v));
            F3_LW:   load_data = XLEN'($signed(w_v));
            // with a 32-bit datapath the full word is the 32-bit lane itself
            F3_LD:   load_data = memdata;
            F3_LBU:  load_data = XLEN'(b_v);
            F3_LHU:  load_data = XLEN'(h_v);
            F3_LWU:  load_data = XLEN'(w_v);
            default: load_data = '0;
        endcase
    end

endmodule

// File: rtl/write_back_unit.sv
// Write-back stage: picks ALU / PC+4 / extracted load data, writes the regfile, pulses retire, counts instret.
// Latency: 1 cycle from accept (or from late memdata_valid) to the retire pulse.
// Backpressure: ready is low only while a load waits for its D-cache data.
module write_back_unit
    import wb_pkg::*;
#(
    parameter int XLEN   = 64,
    parameter int REG_AW = 5,
    parameter int OPC_W  = 12,
    parameter int CNT_W  = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              regW_i_valid,
    output logic              write_back_o_ready,
    input  logic [OPC_W-1:0]  regW_i_opcode_info,
    input  logic [REG_AW-1:0] regW_i_rd,
    input  logic [XLEN-1:0]   regW_i_pc,
    input  logic [XLEN-1:0]   regW_i_alu_result,
    input  logic [XLEN-1:0]   regW_i_memdata,
    input  logic              regW_i_memdata_valid,
    output logic [REG_AW-1:0] write_back_o_rd,
    output logic [XLEN-1:0]   write_back_o_data,
    output logic              write_back_o_reg_wen,
    output logic              write_back_o_retire,
    output logic [XLEN-1:0]   write_back_o_retire_pc,
    output logic [CNT_W-1:0]  write_back_o_instret
);

    localparam int AW = addr_lo_width(XLEN);

    wb_state_e         state_q, state_d;
    logic [REG_AW-1:0] rd_q, rd_d;
    logic [XLEN-1:0]   data_q, data_d;
    logic [XLEN-1:0]   retire_pc_q, retire_pc_d;
    logic              wen_q, wen_d;
    logic              retire_q, retire_d;
    logic [CNT_W-1:0]  instret_q, instret_d;

    // context of a load waiting for its data
    logic [REG_AW-1:0] pend_rd_q, pend_rd_d;
    logic [XLEN-1:0]   pend_pc_q, pend_pc_d;
    logic [2:0]        pend_f3_q, pend_f3_d;
    logic [AW-1:0]     pend_addr_q, pend_addr_d;
    logic              pend_wen_q, pend_wen_d;

    logic              accept;
    logic              in_rd_wen;
    logic              in_is_load;
    logic              in_is_link;
    logic [2:0]        in_f3;
    logic [AW-1:0]     in_addr;
    logic              in_wen;
    logic [2:0]        ext_f3;
    logic [AW-1:0]     ext_addr;
    logic [XLEN-1:0]   ext_data;
    logic              unused_opc_bits;

    assign in_rd_wen  = regW_i_opcode_info[OPC_RD_WEN];
    assign in_is_load = regW_i_opcode_info[OPC_IS_LOAD];
    assign in_is_link = regW_i_opcode_info[OPC_IS_LINK];
    assign in_f3      = regW_i_opcode_info[OPC_F3_LSB +: OPC_F3_W];
    assign in_addr    = regW_i_alu_result[AW-1:0];
    assign in_wen     = in_rd_wen && (regW_i_rd != '0);
    assign unused_opc_bits = ^regW_i_opcode_info[OPC_W-1:OPC_F3_LSB+OPC_F3_W];

    assign write_back_o_ready = (state_q == S_RUN);
    assign accept             = regW_i_valid && write_back_o_ready;

    // while waiting, the extractor works on the latched lane/type, otherwise on the live inputs
    assign ext_f3   = (state_q == S_WAIT_MEM) ? pend_f3_q   : in_f3;
    assign ext_addr = (state_q == S_WAIT_MEM) ? pend_addr_q : in_addr;

    load_extract #(
        .XLEN (XLEN),
        .AW   (AW)
    ) u_load_extract (
        .memdata   (regW_i_memdata),
        .addr_lo   (ext_addr),
        .funct3    (ext_f3),
        .load_data (ext_data)
    );

    // next-state, result selection and retire generation
    always_comb begin
        state_d     = state_q;
        rd_d        = rd_q;
        data_d      = data_q;
        retire_pc_d = retire_pc_q;
        wen_d       = 1'b0;
        retire_d    = 1'b0;
        pend_rd_d   = pend_rd_q;
        pend_pc_d   = pend_pc_q;
        pend_f3_d   = pend_f3_q;
        pend_addr_d = pend_addr_q;
        pend_wen_d  = pend_wen_q;

        case (state_q)
            S_RUN: begin
                if (accept) begin
                    if (in_is_load && !regW_i_memdata_valid) begin
                        state_d     = S_WAIT_MEM;
                        pend_rd_d   = regW_i_rd;
                        pend_pc_d   = regW_i_pc;
                        pend_f3_d   = in_f3;
                        pend_addr_d = in_addr;
                        pend_wen_d  = in_wen;
                    end else begin
                        retire_d    = 1'b1;
                        wen_d       = in_wen;
                        rd_d        = regW_i_rd;
                        retire_pc_d = regW_i_pc;
                        if (in_is_load) begin
                            data_d = ext_data;
                        end else if (in_is_link) begin
                            data_d = regW_i_pc + XLEN'(4);
                        end else begin
                            data_d = regW_i_alu_result;
                        end
                    end
                end
            end
            S_WAIT_MEM: begin
                if (regW_i_memdata_valid) begin
                    state_d     = S_RUN;
                    retire_d    = 1'b1;
                    wen_d       = pend_wen_q;
                    rd_d        = pend_rd_q;
                    retire_pc_d = pend_pc_q;
                    data_d      = ext_data;
                end
            end
            default: state_d = S_RUN;
        endcase

        // counts on the same edge that raises retire; wraps naturally
        instret_d = instret_q + CNT_W'(retire_d);
    end

    // state and output registers; reset drops any pending load
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_RUN;
            rd_q        <= '0;
            data_q      <= '0;
            retire_pc_q <= '0;
            wen_q       <= 1'b0;
            retire_q    <= 1'b0;
            instret_q   <= '0;
            pend_rd_q   <= '0;
            pend_pc_q   <= '0;
            pend_f3_q   <= '0;
            pend_addr_q <= '0;
            pend_wen_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            rd_q        <= rd_d;
            data_q      <= data_d;
            retire_pc_q <= retire_pc_d;
            wen_q       <= wen_d;
            retire_q    <= retire_d;
            instret_q   <= instret_d;
            pend_rd_q   <= pend_rd_d;
            pend_pc_q   <= pend_pc_d;
            pend_f3_q   <= pend_f3_d;
            pend_addr_q <= pend_addr_d;
            pend_wen_q  <= pend_wen_d;
        end
    end

    assign write_back_o_rd        = rd_q;
    assign write_back_o_data      = data_q;
    assign write_back_o_reg_wen   = wen_q;
    assign write_back_o_retire    = retire_q;
    assign write_back_o_retire_pc = retire_pc_q;
    assign write_back_o_instret   = instret_q;

endmodule

// File: tb/tb_write_back_unit.sv
// Directed bench for write_back_unit with an in-order retirement model.
// Latency: checks retire one cycle after accept / after late memdata.
// Backpressure: holds valid while ready is low.
module tb_write_back_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid = 1'b0;
    logic        ready;
    logic [11:0] opc = '0;
    logic [4:0]  rd_i = '0;
    logic [63:0] pc_i = '0;
    logic [63:0] alu_i = '0;
    logic [63:0] md_i = '0;
    logic        mdv = 1'b0;
    logic [4:0]  rd_o;
    logic [63:0] data_o;
    logic        wen_o;
    logic        retire_o;
    logic [63:0] rpc_o;
    logic [63:0] instret_o;

    write_back_unit dut (
        .clk                    (clk),
        .rst_n                  (rst_n),
        .regW_i_valid           (valid),
        .write_back_o_ready     (ready),
        .regW_i_opcode_info     (opc),
        .regW_i_rd              (rd_i),
        .regW_i_pc              (pc_i),
        .regW_i_alu_result      (alu_i),
        .regW_i_memdata         (md_i),
        .regW_i_memdata_valid   (mdv),
        .write_back_o_rd        (rd_o),
        .write_back_o_data      (data_o),
        .write_back_o_reg_wen   (wen_o),
        .write_back_o_retire    (retire_o),
        .write_back_o_retire_pc (rpc_o),
        .write_back_o_instret   (instret_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  rd;
        logic [63:0] data;
        logic        wen;
        logic [63:0] pc;
    } exp_t;

    exp_t        q[$];
    exp_t        cur;
    int          n_vec = 0;
    int          n_err = 0;
    logic [63:0] exp_instret = '0;

    localparam logic [11:0] OP_ALU   = 12'h001;
    localparam logic [11:0] OP_ALU_N = 12'h000;
    localparam logic [11:0] OP_JAL   = 12'h005;

    function automatic logic [11:0] op_load(input logic [2:0] f3);
        return {6'b0, f3, 3'b011};
    endfunction

    // reference load semantics written as plain arithmetic on byte offsets
    function automatic logic [63:0] model_load(input logic [63:0] md, input int a, input logic [2:0] f3);
        logic [63:0] v;
        int off;
        v = 64'd0;
        case (f3)
            3'd0, 3'd4: begin
                v = (md >> (8 * a)) & 64'hFF;
                if (f3 == 3'd0 && v >= 64'd128) v = v - 64'd256;
            end
            3'd1, 3'd5: begin
                off = (a / 2) * 2;
                v = (md >> (8 * off)) & 64'hFFFF;
                if (f3 == 3'd1 && v >= 64'd32768) v = v - 64'd65536;
            end
            3'd2, 3'd6: begin
                off = (a / 4) * 4;
                v = (md >> (8 * off)) & 64'hFFFF_FFFF;
                if (f3 == 3'd2 && v >= 64'h8000_0000) v = v - 64'h1_0000_0000;
            end
            3'd3: v = md;
            default: v = 64'd0;
        endcase
        return v;
    endfunction

    function automatic logic [63:0] model_result(input logic [11:0] o, input logic [63:0] pc,
                                                 input logic [63:0] alu, input logic [63:0] md);
        if (o[1]) return model_load(md, int'(alu[2:0]), o[5:3]);
        if (o[2]) return pc + 64'd4;
        return alu;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [11:0] o, input logic [4:0] rd, input logic [63:0] pc,
                            input logic [63:0] alu, input logic [63:0] final_md);
        exp_t e;
        e.rd   = rd;
        e.data = model_result(o, pc, alu, final_md);
        e.wen  = o[0] && (rd != 5'd0);
        e.pc   = pc;
        q.push_back(e);
    endtask

    // present one instruction, wait (bounded) for ready, return one cycle after accept
    task automatic issue(input logic [11:0] o, input logic [4:0] rd, input logic [63:0] pc,
                         input logic [63:0] alu, input logic [63:0] md, input logic v_md);
        bit ok;
        opc = o; rd_i = rd; pc_i = pc; alu_i = alu; md_i = md; mdv = v_md; valid = 1'b1;
        push_exp(o, rd, pc, alu, md);
        ok = 1'b0;
        for (int t = 0; t < 64; t++) begin
            @(negedge clk);
            if (ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_vec++;
            n_err++;
            $display("FAIL issue_timeout: ready stayed 0, required 1");
        end
        @(posedge clk);
        #1;
        valid = 1'b0;
        mdv   = 1'b0;
    endtask

    // every cycle: a retire must match the oldest outstanding instruction
    always @(negedge clk) begin
        if (rst_n) begin
            if (retire_o) begin
                if (q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_retire: retire=1 pc=%h, required no retire", rpc_o);
                end else begin
                    cur = q.pop_front();
                    exp_instret = exp_instret + 64'd1;
                    chk("ret_rd", 64'(rd_o), 64'(cur.rd));
                    chk("ret_data", data_o, cur.data);
                    chk("ret_wen", 64'(wen_o), 64'(cur.wen));
                    chk("ret_pc", rpc_o, cur.pc);
                    chk("ret_instret", instret_o, exp_instret);
                end
            end else begin
                chk("idle_wen", 64'(wen_o), 64'd0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int low_cnt;

        // reset state
        #12;
        chk("rst_ready", 64'(ready), 64'd1);
        chk("rst_retire", 64'(retire_o), 64'd0);
        chk("rst_instret", instret_o, 64'd0);
        chk("rst_data", data_o, 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("ready_after_rst", 64'(ready), 64'd1);

        // back-to-back ALU ops
        issue(OP_ALU, 5'd5, 64'h100, 64'h10, 64'h0, 1'b0);
        chk("b2b_data0", data_o, 64'h10);
        chk("b2b_ready", 64'(ready), 64'd1);
        issue(OP_ALU, 5'd6, 64'h104, 64'h20, 64'h0, 1'b0);
        chk("b2b_data1", data_o, 64'h20);
        chk("b2b_rd1", 64'(rd_o), 64'd6);
        chk("b2b_instret", instret_o, 64'd2);

        // link
        issue(OP_JAL, 5'd1, 64'h8000_0000, 64'hDEAD, 64'h0, 1'b0);
        chk("jal_data", data_o, 64'h8000_0004);
        chk("jal_pc", rpc_o, 64'h8000_0000);

        // loads with data arriving alongside
        issue(op_load(3'b000), 5'd10, 64'h108, 64'h1000_0003, 64'h0000_0000_80FF_0000, 1'b1);
        chk("lb_data", data_o, 64'hFFFF_FFFF_FFFF_FF80);
        issue(op_load(3'b100), 5'd11, 64'h10C, 64'h1000_0003, 64'h0000_0000_80FF_0000, 1'b1);
        chk("lbu_data", data_o, 64'h80);
        issue(op_load(3'b001), 5'd12, 64'h110, 64'h1000_0002, 64'h0000_0000_80FF_0000, 1'b1);
        chk("lh_data", data_o, 64'hFFFF_FFFF_FFFF_80FF);
        issue(op_load(3'b110), 5'd13, 64'h114, 64'h1000_0004, 64'hF123_4567_0000_0000, 1'b1);
        chk("lwu_data", data_o, 64'hF123_4567);
        issue(op_load(3'b010), 5'd14, 64'h118, 64'h1000_0005, 64'hF123_4567_0000_0000, 1'b1);
        chk("lw_mis_data", data_o, 64'hFFFF_FFFF_F123_4567);
        issue(op_load(3'b111), 5'd15, 64'h11C, 64'h1000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
        chk("f3_111_data", data_o, 64'h0);

        // rd = 0 still retires but does not write
        issue(OP_ALU, 5'd0, 64'h120, 64'h55, 64'h0, 1'b0);
        chk("rd0_wen", 64'(wen_o), 64'd0);
        chk("rd0_retire", 64'(retire_o), 64'd1);
        chk("rd0_instret", instret_o, 64'd10);
        issue(OP_ALU_N, 5'd8, 64'h124, 64'h66, 64'h0, 1'b0);
        chk("nowen_wen", 64'(wen_o), 64'd0);

        // late load data: memdata_valid low in the accept cycle and two more
        issue(op_load(3'b011), 5'd9, 64'h200, 64'h3000, 64'h0, 1'b0);
        q.pop_back();
        push_exp(op_load(3'b011), 5'd9, 64'h200, 64'h3000, 64'h1122_3344_5566_7788);
        opc = OP_ALU; rd_i = 5'd7; pc_i = 64'h204; alu_i = 64'h77; valid = 1'b1;
        push_exp(OP_ALU, 5'd7, 64'h204, 64'h77, 64'h0);
        low_cnt = 0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            if (!ready) low_cnt++;
            @(posedge clk); #1;
        end
        mdv = 1'b1; md_i = 64'h1122_3344_5566_7788;
        @(negedge clk);
        if (!ready) low_cnt++;
        @(posedge clk); #1;
        mdv = 1'b0; md_i = 64'h0;
        chk("late_data", data_o, 64'h1122_3344_5566_7788);
        chk("late_retire", 64'(retire_o), 64'd1);
        chk("late_ready", 64'(ready), 64'd1);
        chk("late_low_cycles", 64'(low_cnt), 64'd3);
        @(posedge clk); #1;
        valid = 1'b0;
        chk("held_data", data_o, 64'h77);
        chk("held_instret", instret_o, 64'd13);

        // reset while a load is pending
        issue(op_load(3'b010), 5'd3, 64'h300, 64'h4000, 64'h0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        q.delete();
        exp_instret = '0;
        chk("arst_retire", 64'(retire_o), 64'd0);
        chk("arst_data", data_o, 64'd0);
        chk("arst_rd", 64'(rd_o), 64'd0);
        chk("arst_pc", rpc_o, 64'd0);
        chk("arst_instret", instret_o, 64'd0);
        chk("arst_ready", 64'(ready), 64'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        mdv = 1'b1; md_i = 64'hAAAA_BBBB_CCCC_DDDD;
        @(posedge clk); #1;
        mdv = 1'b0;
        chk("post_rst_retire", 64'(retire_o), 64'd0);
        chk("post_rst_ready", 64'(ready), 64'd1);
        issue(OP_ALU, 5'd4, 64'h400, 64'h99, 64'h0, 1'b0);
        chk("post_rst_data", data_o, 64'h99);
        chk("post_rst_instret", instret_o, 64'd1);

        @(posedge clk); #1;
        @(negedge clk);
        chk("drained", 64'(q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
